// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: single-outstanding instruction fetch sequencer with a PC-tagged buffer toward decode
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_M1 = (AW+1)'(FIFO_DEPTH - 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, req_pc_q;
  logic [31:0] instr_q [FIFO_DEPTH];
  logic [31:0] pcs_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q, cnt_d;
  logic push, pop, space;
  assign push = state_q == WAIT && imem_rvalid && !redirect_valid;
  assign pop = if_valid && if_ready && !redirect_valid;
  assign space = redirect_valid || cnt_q < DEPTH;
  assign pc_d = redirect_valid ? redirect_pc & ~32'h3 : push ? pc_q + 32'd4 : pc_q;
  assign cnt_d = redirect_valid ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = en && space ? REQ : IDLE;
      REQ:   state_d = !imem_gnt ? REQ : redirect_valid ? DRAIN : WAIT;
      WAIT:  state_d = imem_rvalid ? (en && (redirect_valid || cnt_q < DEPTH_M1) ? REQ : IDLE)
                                   : redirect_valid ? DRAIN : WAIT;
      DRAIN: state_d = imem_rvalid ? (en && space ? REQ : IDLE) : DRAIN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == REQ && imem_gnt) req_pc_q <= pc_q;
      rd_q  <= redirect_valid ? '0 : rd_q + AW'(pop);
      wr_q  <= redirect_valid ? '0 : wr_q + AW'(push);
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push) begin
      instr_q[wr_q] <= imem_rdata;
      pcs_q[wr_q]   <= req_pc_q;
    end
  assign imem_req  = state_q == REQ;
  assign imem_addr = pc_q;
  assign if_valid  = cnt_q != '0;
  assign if_instr  = if_valid ? instr_q[rd_q] : '0;
  assign if_pc     = if_valid ? pcs_q[rd_q] : '0;
  assign busy      = state_q != IDLE || if_valid;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: randomized memory/decode stimulus checked every cycle against a queue-based fetch model
module tb_imem_fetch_ctrl;
  localparam logic [31:0] RPC = 32'h100;
  localparam int D = 2;
  logic clk = 0, rst_n = 0, en = 0, redirect_valid = 0, imem_gnt = 0, imem_rvalid = 0, if_ready = 0;
  logic [31:0] redirect_pc = 0, imem_rdata = 0;
  logic imem_req, if_valid, busy;
  logic [31:0] imem_addr, if_instr, if_pc;
  imem_fetch_ctrl #(.RESET_PC(RPC), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .busy(busy));
  always #5 clk = ~clk;
  typedef struct packed {logic [31:0] pc; logic [31:0] instr;} ent_t;
  ent_t q[$];
  logic m_req = 0, m_out = 0, m_drop = 0;
  logic [31:0] m_pc = RPC, m_rpc = 0;
  logic [31:0] gnt_log[$], pop_log[$];
  int checks = 0, errors = 0;
  logic req_s = 0;
  logic [31:0] addr_s = 0, paddr = 0;
  logic pend = 0;
  int cnt = 0, req_age = 0, gp = 100, dmin = 0, dmax = 0, gwait = 0;
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [31:0] gl(input int i);
    return i < gnt_log.size() ? gnt_log[i] : 32'hDEAD_DEAD;
  endfunction
  function automatic logic [31:0] pl(input int i);
    return i < pop_log.size() ? pop_log[i] : 32'hDEAD_DEAD;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  task automatic check_model();
    chk("imem_req", imem_req, m_req);
    chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", if_valid, q.size() != 0);
    chk("busy", busy, m_req || m_out || q.size() != 0);
    if (q.size() != 0) begin
      chk("if_pc", if_pc, q[0].pc);
      chk("if_instr", if_instr, q[0].instr);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    check_model();
    req_s = imem_req;
    addr_s = imem_addr;
    redirect_valid = 0;
    imem_gnt = rst_n && req_s && req_age >= gwait && $urandom_range(99) < gp;
    imem_rvalid = rst_n && pend && cnt == 0;
    imem_rdata = imem_rvalid ? word(paddr) : $urandom;
  endtask
  task automatic step();
    int n;
    logic redir, pop, push, space;
    if (!rst_n) begin
      q.delete();
      m_req = 0; m_out = 0; m_drop = 0; m_pc = RPC;
      pend = 0; cnt = 0; req_age = 0;
      return;
    end
    n = q.size();
    redir = redirect_valid;
    pop = n > 0 && if_ready && !redir;
    push = m_out && !m_drop && imem_rvalid && !redir;
    space = redir || n < D;
    if (req_s && imem_gnt) begin
      gnt_log.push_back(addr_s);
      pend = 1; paddr = addr_s; cnt = $urandom_range(dmax, dmin); req_age = 0;
    end else begin
      if (req_s) req_age++;
      if (imem_rvalid) pend = 0;
      else if (pend && cnt > 0) cnt--;
    end
    if (m_req) begin
      if (imem_gnt) begin m_req = 0; m_out = 1; m_drop = redir; m_rpc = m_pc; end
    end else if (!m_out) m_req = en && space;
    else if (imem_rvalid) begin
      m_req = en && (m_drop ? space : (redir || n + 1 < D));
      m_out = 0; m_drop = 0;
    end else if (redir) m_drop = 1;
    if (redir) m_pc = redirect_pc & ~32'h3;
    else if (push) m_pc += 4;
    if (redir) q.delete();
    else begin
      if (pop) begin pop_log.push_back(q[0].pc); void'(q.pop_front()); end
      if (push) q.push_back(ent_t'{pc: m_rpc, instr: imem_rdata});
    end
  endtask
  initial forever begin
    @(posedge clk);
    step();
  end
  task automatic do_reset();
    cyc();
    rst_n = 0;
    cyc();
    cyc();
    chk("rst imem_req", imem_req, 0);
    chk("rst imem_addr", imem_addr, RPC);
    chk("rst if_valid", if_valid, 0);
    chk("rst if_instr", if_instr, 0);
    chk("rst if_pc", if_pc, 0);
    chk("rst busy", busy, 0);
    gnt_log.delete();
    pop_log.delete();
    rst_n = 1;
  endtask
  initial begin
    int gi, pi, hi;
    logic found, stable;
    en = 1; if_ready = 1;
    do_reset();
    repeat (16) cyc();
    for (int i = 0; i < 3; i++) begin
      chk("t1 req addr", gl(i), RPC + 32'(4 * i));
      chk("t1 pop pc", pl(i), RPC + 32'(4 * i));
    end
    if_ready = 0;
    do_reset();
    repeat (15) cyc();
    chk("t2 req idle", imem_req, 0);
    chk("t2 head pc", if_pc, 32'h100);
    chk("t2 head instr", if_instr, word(32'h100));
    chk("t2 grants", gnt_log.size(), 2);
    if_ready = 1;
    repeat (12) cyc();
    chk("t2 third addr", gl(2), 32'h108);
    chk("t2 pop0", pl(0), 32'h100);
    chk("t2 pop1", pl(1), 32'h104);
    dmin = 1; dmax = 3;
    do_reset();
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      cyc();
      found = m_out && !m_drop && !imem_rvalid;
    end
    chk("t3 wait seen", found, 1);
    gi = gnt_log.size(); pi = pop_log.size();
    redirect_valid = 1; redirect_pc = 32'h2003;
    repeat (20) cyc();
    chk("t3 redirect addr", gl(gi), 32'h2000);
    chk("t3 redirect pc", pl(pi), 32'h2000);
    dmin = 0; dmax = 2;
    do_reset();
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      cyc();
      found = m_out && !m_drop && imem_rvalid;
    end
    chk("t4 rvalid seen", found, 1);
    gi = gnt_log.size(); pi = pop_log.size();
    redirect_valid = 1; redirect_pc = 32'h3000;
    repeat (20) cyc();
    chk("t4 redirect addr", gl(gi), 32'h3000);
    chk("t4 redirect pc", pl(pi), 32'h3000);
    dmax = 0; gwait = 3;
    do_reset();
    hi = 0; stable = 1;
    repeat (6) begin
      cyc();
      if (imem_req && gnt_log.size() == 0) begin
        hi++;
        if (imem_addr !== 32'h100) stable = 0;
      end
    end
    chk("t5 req cycles", hi, 4);
    chk("t5 addr stable", stable, 1);
    chk("t5 one grant", gnt_log.size(), 1);
    gwait = 0; dmin = 1; dmax = 3; if_ready = 0;
    do_reset();
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      cyc();
      found = q.size() == 1 && m_out && !m_drop && !imem_rvalid;
    end
    chk("t6 wait with one", found, 1);
    rst_n = 0;
    #1;
    chk("t6 if_valid", if_valid, 0);
    chk("t6 busy", busy, 0);
    chk("t6 imem_req", imem_req, 0);
    cyc();
    cyc();
    gnt_log.delete(); pop_log.delete();
    rst_n = 1; if_ready = 1; imem_rvalid = 1;
    repeat (12) cyc();
    chk("t6 restart addr", gl(0), RPC);
    chk("t6 restart pc", pl(0), RPC);
    gp = 60; dmin = 0; dmax = 3;
    do_reset();
    repeat (4000) begin
      cyc();
      en = $urandom_range(9) < 8;
      if_ready = $urandom_range(9) < 6;
      if ($urandom_range(99) < 3) begin
        redirect_valid = 1;
        redirect_pc = $urandom;
      end
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(999) < 2) rst_n = 0;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
